// File: rtl/iir_biquad_mc_if.sv
// Sample, result, coefficient and channel-clear signals of the multi-channel biquad.
// The DUT connects through the slave modport; the sample source and controller use master.
interface iir_biquad_mc_if #(
    parameter int DW  = 14,
    parameter int OW  = 20,
    parameter int CW  = 18,
    parameter int CHW = 2
);
    logic                  in_valid;
    logic                  in_ready;
    logic [CHW-1:0]        in_ch;
    logic signed [DW-1:0]  din;
    logic                  out_valid;
    logic [CHW-1:0]        out_ch;
    logic signed [OW-1:0]  dout;
    logic                  out_sat;
    logic                  coef_we;
    logic [2:0]            coef_addr;
    logic signed [CW-1:0]  coef_wdata;
    logic                  coef_commit;
    logic                  clr_ch_en;
    logic [CHW-1:0]        clr_ch;

    modport master (
        output in_valid, in_ch, din, coef_we, coef_addr, coef_wdata, coef_commit,
               clr_ch_en, clr_ch,
        input  in_ready, out_valid, out_ch, dout, out_sat
    );

    modport slave (
        input  in_valid, in_ch, din, coef_we, coef_addr, coef_wdata, coef_commit,
               clr_ch_en, clr_ch,
        output in_ready, out_valid, out_ch, dout, out_sat
    );
endinterface

// File: rtl/iir_biquad_mc.sv
// Time-multiplexed Direct Form I biquad serving NCH channels from one MAC, one sample per 4 clocks.
// Shadow/active coefficient banks let software retune without a sample ever seeing a mixed bank.
module iir_biquad_mc #(
    parameter int DW   = 14,
    parameter int OW   = 20,
    parameter int CW   = 18,
    parameter int FRAC = 14,
    parameter int NCH  = 4,
    parameter int CHW  = (NCH > 1) ? $clog2(NCH) : 1
) (
    input logic            clk,
    input logic            n_rst,
    iir_biquad_mc_if.slave bus
);

    localparam int AW = OW + CW + 3;
    localparam int PW = CW + OW;

    localparam logic [CHW:0]         NCH_C  = (CHW+1)'(NCH);
    localparam logic signed [CW-1:0] ONE_Q  = {{(CW-FRAC-1){1'b0}}, 1'b1, {FRAC{1'b0}}};
    localparam logic signed [AW-1:0] HALF   = {{(AW-FRAC){1'b0}}, 1'b1, {(FRAC-1){1'b0}}};
    localparam logic signed [AW-1:0] Y_MAX  = {{(AW-OW+1){1'b0}}, {(OW-1){1'b1}}};
    localparam logic signed [AW-1:0] Y_MIN  = {{(AW-OW+1){1'b1}}, {(OW-1){1'b0}}};

    typedef enum logic [1:0] {S_IDLE, S_MAC, S_SUM, S_OUT} state_t;

    function automatic logic signed [PW-1:0] mul(input logic signed [CW-1:0] c,
                                                 input logic signed [OW-1:0] d);
        return PW'(c) * PW'(d);
    endfunction

    // Round half up, then arithmetic shift back to the sample scale.
    function automatic logic signed [AW-1:0] round_shift(input logic signed [AW-1:0] a);
        logic signed [AW-1:0] t;
        t = a + HALF;
        return t >>> FRAC;
    endfunction

    function automatic logic sat_hit(input logic signed [AW-1:0] v);
        return (v > Y_MAX) || (v < Y_MIN);
    endfunction

    function automatic logic signed [OW-1:0] sat_ow(input logic signed [AW-1:0] v);
        if (v > Y_MAX)      return Y_MAX[OW-1:0];
        else if (v < Y_MIN) return Y_MIN[OW-1:0];
        else                return v[OW-1:0];
    endfunction

    state_t               state;
    logic                 vld_p0;
    logic [CHW-1:0]       ch_p0;
    logic                 clr_hit;
    logic                 commit_pend;

    logic signed [DW-1:0] x0_p0, x1_p0, x2_p0;
    logic signed [OW-1:0] y1_p0, y2_p0;
    logic signed [PW-1:0] pb0_p1, pb1_p1, pb2_p1, pa1_p1, pa2_p1;
    logic signed [AW-1:0] acc_c, ys_c;

    logic signed [DW-1:0] x1_r [NCH];
    logic signed [DW-1:0] x2_r [NCH];
    logic signed [OW-1:0] y1_r [NCH];
    logic signed [OW-1:0] y2_r [NCH];
    logic signed [CW-1:0] coef_sh  [5];
    logic signed [CW-1:0] coef_act [5];

    logic accept, in_ok, clr_ok;

    assign accept = (state == S_IDLE) && bus.in_valid && bus.in_ready;
    assign in_ok  = {1'b0, bus.in_ch}  < NCH_C;
    assign clr_ok = {1'b0, bus.clr_ch} < NCH_C;

    // p0: latch the sample with its channel history at accept
    always_ff @(posedge clk) begin
        if (accept) begin
            x0_p0 <= bus.din;
            if (in_ok) begin
                x1_p0 <= x1_r[bus.in_ch];
                x2_p0 <= x2_r[bus.in_ch];
                y1_p0 <= y1_r[bus.in_ch];
                y2_p0 <= y2_r[bus.in_ch];
            end
        end
    end

    // p1: five full-precision products, all from the active bank in one cycle
    always_ff @(posedge clk) begin
        if (state == S_MAC) begin
            pb0_p1 <= mul(coef_act[0], OW'(x0_p0));
            pb1_p1 <= mul(coef_act[1], OW'(x1_p0));
            pb2_p1 <= mul(coef_act[2], OW'(x2_p0));
            pa1_p1 <= mul(coef_act[3], y1_p0);
            pa2_p1 <= mul(coef_act[4], y2_p0);
        end
    end

    // p2: accumulate before scaling, then round and clamp on the way to dout
    always_comb begin
        acc_c = AW'(pb0_p1) + AW'(pb1_p1) + AW'(pb2_p1) - AW'(pa1_p1) - AW'(pa2_p1);
        ys_c  = round_shift(acc_c);
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state         <= S_IDLE;
            bus.in_ready  <= 1'b1;
            bus.out_valid <= 1'b0;
            bus.out_ch    <= '0;
            bus.dout      <= '0;
            bus.out_sat   <= 1'b0;
            vld_p0        <= 1'b0;
            ch_p0         <= '0;
            clr_hit       <= 1'b0;
            commit_pend   <= 1'b0;
            for (int i = 0; i < NCH; i++) begin
                x1_r[i] <= '0;
                x2_r[i] <= '0;
                y1_r[i] <= '0;
                y2_r[i] <= '0;
            end
            for (int i = 0; i < 5; i++) begin
                coef_sh[i]  <= (i == 0) ? ONE_Q : '0;
                coef_act[i] <= (i == 0) ? ONE_Q : '0;
            end
        end else begin
            bus.out_valid <= 1'b0;

            if (bus.coef_we && (bus.coef_addr < 3'd5))
                coef_sh[bus.coef_addr] <= bus.coef_wdata;

            // Bank swap only at IDLE or on the OUT->IDLE edge, so no sample straddles it
            if (bus.coef_commit || commit_pend) begin
                if (state == S_IDLE || state == S_OUT) begin
                    for (int i = 0; i < 5; i++)
                        coef_act[i] <= coef_sh[i];
                    commit_pend <= 1'b0;
                end else begin
                    commit_pend <= 1'b1;
                end
            end

            case (state)
                S_IDLE: begin
                    if (accept) begin
                        ch_p0        <= bus.in_ch;
                        vld_p0       <= in_ok;
                        bus.in_ready <= 1'b0;
                        state        <= S_MAC;
                    end
                end
                S_MAC: state <= S_SUM;
                S_SUM: begin
                    if (vld_p0) begin
                        bus.dout      <= sat_ow(ys_c);
                        bus.out_sat   <= sat_hit(ys_c);
                        bus.out_ch    <= ch_p0;
                        bus.out_valid <= 1'b1;
                    end
                    state <= S_OUT;
                end
                S_OUT: begin
                    if (vld_p0 && !clr_hit) begin
                        x2_r[ch_p0] <= x1_p0;
                        x1_r[ch_p0] <= x0_p0;
                        y2_r[ch_p0] <= y1_p0;
                        y1_r[ch_p0] <= bus.dout;
                    end
                    bus.in_ready <= 1'b1;
                    state        <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase

            // A clear of the in-flight channel at any point suppresses its write-back
            if (accept)
                clr_hit <= bus.clr_ch_en && (bus.clr_ch == bus.in_ch);
            else if (state != S_IDLE && bus.clr_ch_en && (bus.clr_ch == ch_p0))
                clr_hit <= 1'b1;

            if (bus.clr_ch_en && clr_ok) begin
                x1_r[bus.clr_ch] <= '0;
                x2_r[bus.clr_ch] <= '0;
                y1_r[bus.clr_ch] <= '0;
                y2_r[bus.clr_ch] <= '0;
            end
        end
    end

endmodule

// File: tb/tb_iir_biquad_mc.sv
// Directed bench for iir_biquad_mc with hand-computed expected outputs.
// CW is widened to 24 so a gain of 127.0 is representable for the saturation vectors.
module tb_iir_biquad_mc;

    localparam int DW   = 14;
    localparam int OW   = 20;
    localparam int CW   = 24;
    localparam int FRAC = 14;
    localparam int NCH  = 4;
    localparam int CHW  = 2;

    logic clk = 1'b0;
    logic n_rst;
    always #5 clk = ~clk;

    iir_biquad_mc_if #(.DW(DW), .OW(OW), .CW(CW), .CHW(CHW)) bus ();

    iir_biquad_mc #(
        .DW(DW), .OW(OW), .CW(CW), .FRAC(FRAC), .NCH(NCH), .CHW(CHW)
    ) dut (
        .clk   (clk),
        .n_rst (n_rst),
        .bus   (bus)
    );

    int n_chk = 0;
    int n_err = 0;

    task automatic check(input string tag, input int act, input int exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    task automatic set_coef(input int addr, input int val);
        bus.coef_addr  = 3'(addr);
        bus.coef_wdata = CW'(val);
        bus.coef_we    = 1'b1;
        @(negedge clk);
        bus.coef_we    = 1'b0;
    endtask

    task automatic commit();
        bus.coef_commit = 1'b1;
        @(negedge clk);
        bus.coef_commit = 1'b0;
    endtask

    task automatic clear(input int ch);
        bus.clr_ch    = CHW'(ch);
        bus.clr_ch_en = 1'b1;
        @(negedge clk);
        bus.clr_ch_en = 1'b0;
    endtask

    // Sends one sample and checks dout, out_sat, out_ch and accept-to-output latency.
    task automatic sample(input string tag, input int ch, input int x, input int exp_y,
                          input int exp_sat, input bit mac_commit, input bit mac_clr);
        int w;
        int lat;
        w = 0;
        while (!bus.in_ready && w < 20) begin
            @(negedge clk);
            w++;
        end
        check({tag, "_rdy"}, int'(bus.in_ready), 1);
        bus.in_ch    = CHW'(ch);
        bus.din      = DW'(x);
        bus.in_valid = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        lat = 1;
        if (mac_commit) bus.coef_commit = 1'b1;
        if (mac_clr) begin
            bus.clr_ch    = CHW'(ch);
            bus.clr_ch_en = 1'b1;
        end
        while (!bus.out_valid && lat < 10) begin
            @(negedge clk);
            lat++;
            bus.coef_commit = 1'b0;
            bus.clr_ch_en   = 1'b0;
        end
        check({tag, "_lat"},  lat, 3);
        check({tag, "_dout"}, int'(bus.dout), exp_y);
        check({tag, "_sat"},  int'(bus.out_sat), exp_sat);
        check({tag, "_ch"},   int'(bus.out_ch), ch);
    endtask

    int step_exp [7] = '{1000, 1500, 1750, 1875, 1938, 1969, 1985};
    int imp_x    [4] = '{1000, 0, 0, 0};
    int imp_exp  [4] = '{250, 250, 250, 0};

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int bad;
        n_rst           = 1'b0;
        bus.in_valid    = 1'b0;
        bus.in_ch       = '0;
        bus.din         = '0;
        bus.coef_we     = 1'b0;
        bus.coef_addr   = '0;
        bus.coef_wdata  = '0;
        bus.coef_commit = 1'b0;
        bus.clr_ch_en   = 1'b0;
        bus.clr_ch      = '0;
        repeat (2) @(negedge clk);
        check("rst_in_ready",  int'(bus.in_ready), 1);
        check("rst_out_valid", int'(bus.out_valid), 0);
        check("rst_dout",      int'(bus.dout), 0);
        check("rst_out_ch",    int'(bus.out_ch), 0);
        check("rst_out_sat",   int'(bus.out_sat), 0);
        n_rst = 1'b1;
        @(negedge clk);

        // 1: default pass-through bank
        sample("t1", 0, 100, 100, 0, 0, 0);
        @(negedge clk);
        check("t1_ready_back", int'(bus.in_ready), 1);
        check("t1_valid_pulse", int'(bus.out_valid), 0);

        // 2: 3-tap FIR of 0.25 each, impulse on ch1
        set_coef(0, 4096);
        set_coef(1, 4096);
        set_coef(2, 4096);
        commit();
        for (int i = 0; i < 4; i++)
            sample($sformatf("t2_imp%0d", i), 1, imp_x[i], imp_exp[i], 0, 0, 0);

        // 3: one-pole, a1=-0.5; step on ch2, ch0 keeps its own history, ch3 untouched
        set_coef(0, 16384);
        set_coef(1, 0);
        set_coef(2, 0);
        set_coef(3, -8192);
        commit();
        for (int i = 0; i < 7; i++)
            sample($sformatf("t3_step%0d", i), 2, 1000, step_exp[i], 0, 0, 0);
        sample("t3_ch0", 0, 100, 150, 0, 0, 0);
        sample("t3_ch3", 3, 0, 0, 0, 0, 0);

        // 4: saturation and rounding boundaries
        set_coef(0, 127 * 16384);
        set_coef(3, 0);
        commit();
        sample("t4_pos_sat", 3, 8191, 524287, 1, 0, 0);
        sample("t4_neg_sat", 3, -8192, -524288, 1, 0, 0);
        set_coef(0, 4096);
        commit();
        sample("t4_rnd_m3", 3, -3, -1, 0, 0, 0);
        sample("t4_rnd_p2", 3, 2, 1, 0, 0, 0);
        sample("t4_rnd_m2", 3, -2, 0, 0, 0, 0);

        // 5: commit while busy is deferred; same-cycle write+commit takes the old shadow
        set_coef(0, 16384);
        sample("t5_old_bank", 3, 400, 100, 0, 1, 0);
        sample("t5_new_bank", 3, 400, 400, 0, 0, 0);
        bus.coef_addr   = 3'd0;
        bus.coef_wdata  = CW'(8192);
        bus.coef_we     = 1'b1;
        bus.coef_commit = 1'b1;
        @(negedge clk);
        bus.coef_we     = 1'b0;
        bus.coef_commit = 1'b0;
        sample("t5_prewrite", 3, 400, 400, 0, 0, 0);
        commit();
        sample("t5_postwrite", 3, 400, 200, 0, 0, 0);

        // 6: interleaved channels with a clear of the in-flight channel
        set_coef(0, 16384);
        set_coef(3, -8192);
        commit();
        clear(0);
        clear(1);
        sample("t6_c0a", 0, 1000, 1000, 0, 0, 0);
        sample("t6_c1a", 1, 1000, 1000, 0, 0, 0);
        sample("t6_c0b", 0, 1000, 1500, 0, 0, 0);
        sample("t6_c1_clr", 1, 1000, 1500, 0, 0, 1);
        sample("t6_c1_fresh", 1, 1000, 1000, 0, 0, 0);
        sample("t6_c0c", 0, 1000, 1750, 0, 0, 0);

        // Reset asserted while the sample is in SUM
        @(negedge clk);
        bus.in_ch    = 2'd0;
        bus.din      = DW'(1000);
        bus.in_valid = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        @(negedge clk);
        n_rst = 1'b0;
        bad = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (bus.out_valid) bad++;
        end
        check("t6_rst_no_out", bad, 0);
        check("t6_rst_dout", int'(bus.dout), 0);
        check("t6_rst_ready", int'(bus.in_ready), 1);
        n_rst = 1'b1;
        @(negedge clk);
        set_coef(3, -8192);
        commit();
        sample("t6_post_rst0", 0, 500, 500, 0, 0, 0);
        sample("t6_post_rst1", 0, 500, 750, 0, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
